// File: rtl/u21_probe.sv
`timescale 1ns/1ps
// u21_probe: characterises a two-input universal gate by driving all four
// input vectors (00, 01, 10, 11), waiting SETTLE cycles after each one and
// sampling gate_out. The recovered truth table is published on func as
// func[{a,b}] = f(a,b), together with an "unstable" flag. The flag is set if
// gate_out moved while a vector was being held, ignoring the first cycle of
// each vector.
//
// Optional feature: define U21_PROBE_CHECK_EN to add the expect_func input
// and the mismatch output. The expected code is captured when a run starts.
// mismatch reports (func != expected code) at the done pulse. The port is
// called expect_func because "expect" is a reserved SystemVerilog keyword.
module u21_probe #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       gate_out,
`ifdef U21_PROBE_CHECK_EN
  input  logic [3:0] expect_func,
  output logic       mismatch,
`endif
  output logic       test_a,
  output logic       test_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] func,
  output logic       unstable
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  // With no settle time every vector is a single SAMPLE cycle.
  localparam bit         NO_SETTLE = (SETTLE == 0);
  localparam logic [3:0] LAST_CNT  = NO_SETTLE ? 4'd0 : 4'(SETTLE - 1);

  state_t     state;
  logic [1:0] k;
  logic [3:0] cnt;
  logic [3:0] shadow;
  logic       first_cyc;
  logic       prev_gate;
  logic       trk;

  logic       glitch_seen;
  logic       trk_next;
  logic [3:0] shadow_next;

`ifdef U21_PROBE_CHECK_EN
  logic [3:0] expect_q;
`endif

  // Detect gate_out movement inside a vector's window and build the result
  // that includes the sample being taken this cycle.
  always_comb begin
    glitch_seen = 1'b0;
    if ((state == DRIVE || state == SAMPLE) && !first_cyc && (gate_out != prev_gate))
      glitch_seen = 1'b1;
    trk_next       = trk | glitch_seen;
    shadow_next    = shadow;
    shadow_next[k] = gate_out;
  end

  // Probe sequencer: the state, the counters and every output are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= 2'd0;
      cnt       <= 4'd0;
      shadow    <= 4'd0;
      first_cyc <= 1'b0;
      prev_gate <= 1'b0;
      trk       <= 1'b0;
      test_a    <= 1'b0;
      test_b    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      func      <= 4'd0;
      unstable  <= 1'b0;
`ifdef U21_PROBE_CHECK_EN
      expect_q  <= 4'd0;
      mismatch  <= 1'b0;
`endif
    end else begin
      prev_gate <= gate_out;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            k         <= 2'd0;
            cnt       <= 4'd0;
            shadow    <= 4'd0;
            trk       <= 1'b0;
            first_cyc <= 1'b1;
            busy      <= 1'b1;
            test_a    <= 1'b0;
            test_b    <= 1'b0;
`ifdef U21_PROBE_CHECK_EN
            expect_q  <= expect_func;
`endif
            if (NO_SETTLE) state <= SAMPLE;
            else           state <= DRIVE;
          end
        end
        DRIVE: begin
          first_cyc <= 1'b0;
          trk       <= trk_next;
          if (cnt == LAST_CNT) state <= SAMPLE;
          else                 cnt   <= cnt + 4'd1;
        end
        SAMPLE: begin
          shadow <= shadow_next;
          trk    <= trk_next;
          if (k == 2'd3) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            func     <= shadow_next;
            unstable <= trk_next;
            test_a   <= 1'b0;
            test_b   <= 1'b0;
`ifdef U21_PROBE_CHECK_EN
            mismatch <= (shadow_next != expect_q);
`endif
          end else begin
            k                <= k + 2'd1;
            cnt              <= 4'd0;
            first_cyc        <= 1'b1;
            {test_a, test_b} <= k + 2'd1;
            if (NO_SETTLE) state <= SAMPLE;
            else           state <= DRIVE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_u21_probe.sv
`timescale 1ns/1ps
// Testbench for u21_probe. Two instances are used: one with SETTLE=2 and one
// with SETTLE=0. Both share a behavioural gate model, which can be forced to
// glitch for one cycle. The expected results of each run go into a
// scoreboard queue when start is driven. Each entry is popped and compared
// when the done pulse appears. All outputs are also checked cycle by cycle.
module tb_u21_probe;

  typedef struct {
    logic [3:0] func;
    logic       unst;
    logic       mis;
    int         at;
  } exp_t;

  localparam int G_AND = 0, G_OR = 1, G_XOR = 2, G_NAND = 3, G_NOR = 4;

  logic clk = 1'b0;
  logic rst;
  logic start2, start0;
  logic glitch;
  int   gate_kind;
  logic [3:0] exp_in;
  logic sel0;

  logic gate_out2, gate_out0;
  logic a2, b2, busy2, done2, unst2;
  logic a0, b0, busy0, done0, unst0;
  logic [3:0] func2, func0;
  logic mis2, mis0;

  logic o_a, o_b, o_busy, o_done, o_unst, o_mis;
  logic [3:0] o_func;

  int total = 0;
  int bad = 0;
  exp_t sb[$];

  logic [3:0] last_func2 = 4'd0, last_func0 = 4'd0;
  logic       last_unst2 = 1'b0, last_unst0 = 1'b0;
  logic       last_mis2  = 1'b0, last_mis0  = 1'b0;

  always #5 clk = ~clk;

  // Behavioural gate under test, built from the logical operators themselves.
  function automatic logic gate_fn(input int kind, input logic a, input logic b);
    case (kind)
      G_AND:   return a & b;
      G_OR:    return a | b;
      G_XOR:   return a ^ b;
      G_NAND:  return ~(a & b);
      default: return ~(a | b);
    endcase
  endfunction

  assign gate_out2 = gate_fn(gate_kind, a2, b2) ^ glitch;
  assign gate_out0 = gate_fn(gate_kind, a0, b0) ^ glitch;

  assign o_a    = sel0 ? a0 : a2;
  assign o_b    = sel0 ? b0 : b2;
  assign o_busy = sel0 ? busy0 : busy2;
  assign o_done = sel0 ? done0 : done2;
  assign o_func = sel0 ? func0 : func2;
  assign o_unst = sel0 ? unst0 : unst2;

`ifndef U21_PROBE_CHECK_EN
  assign mis2 = 1'b0;
  assign mis0 = 1'b0;
`endif
  assign o_mis = sel0 ? mis0 : mis2;

  u21_probe #(.SETTLE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .gate_out(gate_out2),
`ifdef U21_PROBE_CHECK_EN
    .expect_func(exp_in), .mismatch(mis2),
`endif
    .test_a(a2), .test_b(b2), .busy(busy2), .done(done2),
    .func(func2), .unstable(unst2)
  );

  u21_probe #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .gate_out(gate_out0),
`ifdef U21_PROBE_CHECK_EN
    .expect_func(exp_in), .mismatch(mis0),
`endif
    .test_a(a0), .test_b(b0), .busy(busy0), .done(done0),
    .func(func0), .unstable(unst0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One probe run on the selected instance. Negative cycle numbers disable
  // the optional glitch, start re-pulse and reset events.
  task automatic applyStimulus(input logic use0, input int kind, input logic [3:0] exp_func,
                               input logic exp_unst, input logic [3:0] exp_code,
                               input int glitch_at, input int restart_at, input int rst_at);
    int s, lat;
    logic act;
    logic [1:0] tv_exp;
    logic [3:0] old_func, want_func;
    logic old_unst, old_mis, new_mis, want_unst, want_mis;
    exp_t e;
    sel0      = use0;
    gate_kind = kind;
    exp_in    = exp_code;
    s         = use0 ? 0 : 2;
    lat       = 4 * (s + 1) + 1;
    old_func  = use0 ? last_func0 : last_func2;
    old_unst  = use0 ? last_unst0 : last_unst2;
    old_mis   = use0 ? last_mis0 : last_mis2;
    new_mis   = (exp_func != exp_code);
    if (rst_at < 0) begin
      e = '{exp_func, exp_unst, new_mis, lat};
      sb.push_back(e);
    end
    if (use0) start0 = 1'b1;
    else      start2 = 1'b1;
    for (int c = 1; c <= lat + 2; c++) begin
      tick();
      act    = (c < lat) && (rst_at < 0 || c <= rst_at);
      tv_exp = act ? 2'((c - 1) / (s + 1)) : 2'b00;
      if (rst_at >= 0 && c > rst_at) begin
        want_func = 4'd0; want_unst = 1'b0; want_mis = 1'b0;
      end else if (c >= lat) begin
        want_func = exp_func; want_unst = exp_unst; want_mis = new_mis;
      end else begin
        want_func = old_func; want_unst = old_unst; want_mis = old_mis;
      end
      checkOutput($sformatf("busy@%0d", c), 32'(o_busy), 32'(act));
      checkOutput($sformatf("test_ab@%0d", c), 32'({o_a, o_b}), 32'(tv_exp));
      checkOutput($sformatf("done@%0d", c), 32'(o_done), 32'(c == lat && rst_at < 0));
      checkOutput($sformatf("func@%0d", c), 32'(o_func), 32'(want_func));
      checkOutput($sformatf("unstable@%0d", c), 32'(o_unst), 32'(want_unst));
`ifdef U21_PROBE_CHECK_EN
      checkOutput($sformatf("mismatch@%0d", c), 32'(o_mis), 32'(want_mis));
`endif
      if (o_done === 1'b1) begin
        checkOutput("sb_pending", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput("sb_func", 32'(o_func), 32'(e.func));
          checkOutput("sb_unstable", 32'(o_unst), 32'(e.unst));
          checkOutput("sb_latency", 32'(c), 32'(e.at));
`ifdef U21_PROBE_CHECK_EN
          checkOutput("sb_mismatch", 32'(o_mis), 32'(e.mis));
`endif
        end
      end
      start0 = 1'b0;
      start2 = 1'b0;
      glitch = 1'b0;
      rst    = 1'b0;
      if (restart_at >= 0 && (c == restart_at || c == lat)) begin
        if (use0) start0 = 1'b1;
        else      start2 = 1'b1;
      end
      if (c == glitch_at) glitch = 1'b1;
      if (c == rst_at)    rst    = 1'b1;
    end
    start0 = 1'b0;
    start2 = 1'b0;
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    if (rst_at >= 0) begin
      last_func0 = 4'd0; last_unst0 = 1'b0; last_mis0 = 1'b0;
      last_func2 = 4'd0; last_unst2 = 1'b0; last_mis2 = 1'b0;
    end else if (use0) begin
      last_func0 = exp_func; last_unst0 = exp_unst; last_mis0 = new_mis;
    end else begin
      last_func2 = exp_func; last_unst2 = exp_unst; last_mis2 = new_mis;
    end
  endtask

  // Directed sequence: the reset state first, then each probe scenario.
  initial begin
    rst       = 1'b1;
    start2    = 1'b1;
    start0    = 1'b1;
    glitch    = 1'b0;
    gate_kind = G_AND;
    exp_in    = 4'd0;
    sel0      = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      sel0 = (i == 1);
      checkOutput("rst_busy", 32'(o_busy), 32'd0);
      checkOutput("rst_done", 32'(o_done), 32'd0);
      checkOutput("rst_func", 32'(o_func), 32'd0);
      checkOutput("rst_unstable", 32'(o_unst), 32'd0);
      checkOutput("rst_test_ab", 32'({o_a, o_b}), 32'd0);
      checkOutput("rst_mismatch", 32'(o_mis), 32'd0);
    end
    rst    = 1'b0;
    start2 = 1'b0;
    start0 = 1'b0;
    tick();
    $display("[TB] AND probe, SETTLE=2");
    applyStimulus(1'b0, G_AND, 4'b1000, 1'b0, 4'b1000, -1, -1, -1);
    $display("[TB] XOR probe, SETTLE=0");
    applyStimulus(1'b1, G_XOR, 4'b0110, 1'b0, 4'b0110, -1, -1, -1);
    $display("[TB] OR probe with start re-pulsed mid-run and in DONE");
    applyStimulus(1'b0, G_OR, 4'b1110, 1'b0, 4'b1110, -1, 4, -1);
    $display("[TB] XOR probe aborted by reset at cycle 6");
    applyStimulus(1'b0, G_XOR, 4'b0110, 1'b0, 4'b0110, -1, -1, 6);
    $display("[TB] XOR probe with glitch on vector 2");
    applyStimulus(1'b0, G_XOR, 4'b0110, 1'b1, 4'b0110, 8, -1, -1);
    $display("[TB] clean NAND probe");
    applyStimulus(1'b0, G_NAND, 4'b0111, 1'b0, 4'b0111, -1, -1, -1);
    $display("[TB] OR probe against expected 1110");
    applyStimulus(1'b0, G_OR, 4'b1110, 1'b0, 4'b1110, -1, -1, -1);
    $display("[TB] NOR probe against expected 1110");
    applyStimulus(1'b0, G_NOR, 4'b0001, 1'b0, 4'b1110, -1, -1, -1);
    $display("[TB] NAND probe, SETTLE=0");
    applyStimulus(1'b1, G_NAND, 4'b0111, 1'b0, 4'b0000, -1, -1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the simulation can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
